// File: rtl/multicore_pkg.sv
// multicore_pkg: shared types and constants for the system-instruction unit.
`default_nettype none

package multicore_pkg;

  localparam int DATA_SIZE = 32;
  localparam int SYS_CNT_W = 64;

  // Bit 0 selects low/high word; bits [2:1] select cycle/time/instret/trap.
  typedef enum logic [2:0] {
    RDCYCLE    = 3'd0,
    RDCYCLEH   = 3'd1,
    RDTIME     = 3'd2,
    RDTIMEH    = 3'd3,
    RDINSTRET  = 3'd4,
    RDINSTRETH = 3'd5,
    SCALL      = 3'd6,
    SBREAK     = 3'd7
  } t_sysop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    TRAP = 2'd2
  } t_sys_state;

  function automatic logic is_trap_op(input t_sysop op);
    return (op == SCALL) || (op == SBREAK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_counter64.sv
// sys_counter64: free-running wrapping counter with synchronous reset and enable.
`default_nettype none

module sys_counter64
  import multicore_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  output logic [SYS_CNT_W-1:0] o_count
);

  logic [SYS_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(SYS_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/exe_system_unit.sv
// exe_system_unit: cycle/time/instret counter reads plus SCALL/SBREAK handling.
// Define SYSUNIT_TRAP_EN to route SCALL/SBREAK to the trap handshake instead of a zero read.
`default_nettype none

module exe_system_unit
  import multicore_pkg::*;
#(
  parameter int TIME_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  t_sysop               req_op,
  input  logic [4:0]           req_rd,
  output logic                 resp_valid,
  output logic [DATA_SIZE-1:0] resp_data,
  output logic [4:0]           resp_rd,
  input  logic                 retire,
  output logic                 trap_valid,
  output logic                 trap_cause,
  input  logic                 trap_ack
);

  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  logic [PW-1:0]        r_presc;
  logic                 w_tick;
  logic [SYS_CNT_W-1:0] w_cycle;
  logic [SYS_CNT_W-1:0] w_time;
  logic [SYS_CNT_W-1:0] w_instret;
  logic [SYS_CNT_W-1:0] w_sel_cnt;
  logic [DATA_SIZE-1:0] w_word;
  logic                 w_accept;
  t_sys_state           r_state;
  t_sys_state           w_next;
  logic [DATA_SIZE-1:0] r_resp_data;
  logic [4:0]           r_resp_rd;

  assign w_tick = (r_presc == PW'(TIME_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  sys_counter64 u_cycle   (.clk(clk), .rst(rst), .i_en(1'b1),   .o_count(w_cycle));
  sys_counter64 u_time    (.clk(clk), .rst(rst), .i_en(w_tick), .o_count(w_time));
  sys_counter64 u_instret (.clk(clk), .rst(rst), .i_en(retire), .o_count(w_instret));

  // Sampled from the registers before this edge's increment lands.
  always_comb begin
    w_sel_cnt = '0;
    case (req_op[2:1])
      2'b00:   w_sel_cnt = w_cycle;
      2'b01:   w_sel_cnt = w_time;
      2'b10:   w_sel_cnt = w_instret;
      default: w_sel_cnt = '0;
    endcase
    w_word = req_op[0] ? w_sel_cnt[SYS_CNT_W-1:DATA_SIZE] : w_sel_cnt[DATA_SIZE-1:0];
  end

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: begin
        w_next = IDLE;
        if (w_accept) begin
`ifdef SYSUNIT_TRAP_EN
          w_next = is_trap_op(req_op) ? TRAP : RESP;
`else
          w_next = RESP;
`endif
        end
      end
`ifdef SYSUNIT_TRAP_EN
      TRAP: begin
        if (trap_ack) begin
          w_next = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_data <= '0;
      r_resp_rd   <= '0;
    end else if (w_accept) begin
      r_resp_data <= w_word;
      r_resp_rd   <= req_rd;
    end
  end

`ifdef SYSUNIT_TRAP_EN
  logic r_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause <= 1'b0;
    end else if (w_accept) begin
      r_cause <= req_op[0];
    end
  end

  always_comb begin
    trap_valid = (r_state == TRAP);
    trap_cause = trap_valid ? r_cause : 1'b0;
  end
`else
  logic w_unused_trap_ack;
  assign w_unused_trap_ack = trap_ack;

  always_comb begin
    trap_valid = 1'b0;
    trap_cause = 1'b0;
  end
`endif

  always_comb begin
    req_ready  = !rst && (r_state != TRAP);
    resp_valid = (r_state == RESP);
    resp_data  = resp_valid ? r_resp_data : '0;
    resp_rd    = resp_valid ? r_resp_rd : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_system_unit.sv
// tb_exe_system_unit: directed checks of counter reads, wrap, retire timing and SCALL/SBREAK.
`default_nettype none

module tb_exe_system_unit;
  import multicore_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  t_sysop      req_op;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        retire;
  logic        trap_valid;
  logic        trap_cause;
  logic        trap_ack;

  int n_tests = 0;
  int n_fail  = 0;

  exe_system_unit #(.TIME_DIV(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_ack(trap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input t_sysop op, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = RDCYCLE; req_rd = '0;
    retire = 1'b0; trap_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_rrd", resp_rd, 0);
    chk("rst_tvalid", trap_valid, 0);
    chk("rst_tcause", trap_cause, 0);

    // RDCYCLE after 100 cycles out of reset
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("ready_idle", req_ready, 1);
    issue(RDCYCLE, 5'd7);
    @(negedge clk);
    req_valid = 1'b0;
    chk("cyc_valid", resp_valid, 1);
    chk("cyc_data", resp_data, 100);
    chk("cyc_rd", resp_rd, 7);
    @(negedge clk);
    chk("cyc_one_shot", resp_valid, 0);

    // time prescaler
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (95) @(negedge clk);
    issue(RDTIME, 5'd3);
    @(negedge clk);
    req_valid = 1'b0;
    chk("time_9", resp_data, 9);
    repeat (9) @(negedge clk);
    issue(RDTIME, 5'd4);
    @(negedge clk);
    chk("time_10", resp_data, 10);
    issue(RDTIMEH, 5'd5);
    @(negedge clk);
    req_valid = 1'b0;
    chk("timeh_valid", resp_valid, 1);
    chk("timeh_data", resp_data, 0);
    chk("timeh_rd", resp_rd, 5);

    // retire coincident with RDINSTRET accept
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retire = 1'b1;
      @(negedge clk);
      retire = 1'b0;
      @(negedge clk);
    end
    retire = 1'b1;
    issue(RDINSTRET, 5'd9);
    @(negedge clk);
    retire = 1'b0;
    chk("instret_6", resp_data, 6);
    issue(RDINSTRET, 5'd10);
    @(negedge clk);
    chk("instret_7", resp_data, 7);
    chk("instret_rd", resp_rd, 10);
    issue(RDINSTRETH, 5'd11);
    @(negedge clk);
    req_valid = 1'b0;
    chk("instreth_0", resp_data, 0);

    // low-word carry into high word
    @(negedge clk);
    force dut.u_cycle.r_count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_cycle.r_count;
    issue(RDCYCLE, 5'd1);
    @(negedge clk);
    chk("carry_lo", resp_data, 32'hFFFF_FFFF);
    issue(RDCYCLEH, 5'd2);
    @(negedge clk);
    req_valid = 1'b0;
    chk("carry_hi", resp_data, 1);
    chk("carry_hi_valid", resp_valid, 1);

    // 64-bit wrap to zero
    @(negedge clk);
    force dut.u_cycle.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_cycle.r_count;
    issue(RDCYCLEH, 5'd3);
    @(negedge clk);
    chk("wrap_hi_ones", resp_data, 32'hFFFF_FFFF);
    issue(RDCYCLE, 5'd4);
    @(negedge clk);
    chk("wrap_lo_zero", resp_data, 0);
    issue(RDCYCLEH, 5'd5);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrap_hi_zero", resp_data, 0);

`ifdef SYSUNIT_TRAP_EN
    // SCALL: trap held until ack at +5
    @(negedge clk);
    issue(SCALL, 5'd13);
    @(negedge clk);
    req_valid = 1'b0;
    chk("scall_tvalid", trap_valid, 1);
    chk("scall_cause", trap_cause, 0);
    chk("scall_ready", req_ready, 0);
    chk("scall_no_resp", resp_valid, 0);
    repeat (3) @(negedge clk);
    chk("scall_hold", trap_valid, 1);
    chk("scall_hold_ready", req_ready, 0);
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    chk("scall_ack_tvalid", trap_valid, 0);
    chk("scall_ack_ready", req_ready, 1);
    chk("scall_ack_no_resp", resp_valid, 0);

    issue(SBREAK, 5'd14);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sbreak_tvalid", trap_valid, 1);
    chk("sbreak_cause", trap_cause, 1);
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    chk("sbreak_ack", trap_valid, 0);

    // reset while trapped
    issue(SCALL, 5'd15);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("trap_rst_ready", req_ready, 0);
    @(negedge clk);
    chk("trap_rst_tvalid", trap_valid, 0);
    chk("trap_rst_cause", trap_cause, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("trap_rst_idle", req_ready, 1);
`else
    // SCALL/SBREAK complete as zero reads
    @(negedge clk);
    issue(SBREAK, 5'd11);
    @(negedge clk);
    chk("sbreak_valid", resp_valid, 1);
    chk("sbreak_data", resp_data, 0);
    chk("sbreak_rd", resp_rd, 11);
    chk("sbreak_tvalid", trap_valid, 0);
    chk("sbreak_ready", req_ready, 1);
    issue(SCALL, 5'd12);
    @(negedge clk);
    req_valid = 1'b0;
    chk("scall_valid", resp_valid, 1);
    chk("scall_data", resp_data, 0);
    chk("scall_tvalid", trap_valid, 0);
    chk("scall_tcause", trap_cause, 0);
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    chk("stray_ack_ready", req_ready, 1);
    chk("stray_ack_resp", resp_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exe_system_unit.md
EXE_SYSTEM_UNIT -- requirements
Module: exe_system_unit

Interface
REQ-001 Parameter TIME_DIV, default 10, SHALL set the clk cycles per time-counter increment; legal values are >= 1.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port req_valid  input  1  SHALL indicate a system instruction is presented.
REQ-005 Port req_ready  output  1  SHALL indicate the unit accepts a request this cycle.
REQ-006 Port req_op  input  3 (t_sysop)  SHALL carry the system operation.
REQ-007 Port req_rd  input  5  SHALL carry the destination register index.
REQ-008 Port resp_valid  output  1  SHALL flag a one-cycle writeback result.
REQ-009 Port resp_data  output  32 (DATA_SIZE)  SHALL carry the result word.
REQ-010 Port resp_rd  output  5  SHALL echo the req_rd of the accepted request.
REQ-011 Port retire  input  1  SHALL pulse once per retired instruction.
REQ-012 Port trap_valid  output  1  SHALL request a trap from the pipeline.
REQ-013 Port trap_cause  output  1  SHALL be 0 for SCALL and 1 for SBREAK.
REQ-014 Port trap_ack  input  1  SHALL acknowledge a pending trap.

Function
REQ-015 The unit SHALL hold three 64-bit counters: cycle, time and instret, each wrapping from 2^64-1 to 0.
REQ-016 cycle SHALL increment every clk cycle while rst is low.
REQ-017 A prescaler SHALL count 0..TIME_DIV-1; time SHALL increment on the cycle the prescaler equals TIME_DIV-1, and the prescaler SHALL then return to 0.
REQ-018 instret SHALL increment by 1 on each cycle retire is high.
REQ-019 The FSM SHALL have the states IDLE, RESP and TRAP.
REQ-020 A request SHALL be accepted on any cycle with req_valid and req_ready both high.
REQ-021 req_ready SHALL be 1 in IDLE and RESP, and 0 in TRAP and while rst is high.
REQ-022 An accepted RD* op SHALL move the FSM to RESP.
REQ-023 In RESP, resp_valid SHALL be high for exactly one cycle, one cycle after acceptance (latency 1).
REQ-024 resp_data SHALL be the low word for even ops and the high word for odd ops of the selected counter.
REQ-025 The counter value returned SHALL be the one held before the accept edge's own increment.
REQ-026 An accept in RESP SHALL chain to RESP, giving back-to-back responses; with no accept, RESP SHALL return to IDLE.
REQ-027 An accepted SCALL or SBREAK SHALL move the FSM to TRAP with trap_valid=1 and trap_cause set, and SHALL produce no resp_valid.
REQ-028 trap_valid SHALL hold until trap_ack; the FSM SHALL then return to IDLE on the next edge.
REQ-029 trap_ack outside TRAP SHALL be ignored.
REQ-030 retire coincident with an RDINSTRET accept SHALL NOT be visible in that response.

Reset
REQ-031 While rst is high: counters=0, prescaler=0, FSM=IDLE, and all outputs=0.
REQ-032 rst asserted mid-TRAP or mid-RESP SHALL drop trap_valid and resp_valid on the next edge, discarding the pending operation.

Configuration
REQ-033 With SYSUNIT_TRAP_EN defined, SCALL and SBREAK SHALL behave per REQ-027 to REQ-029.
REQ-034 Without SYSUNIT_TRAP_EN, SCALL and SBREAK SHALL complete like reads, with resp_data=0; trap_valid and trap_cause SHALL be tied 0, and the TRAP state SHALL be absent.

Structure
REQ-035 multicore_pkg SHALL gain SYS_CNT_W=64 and the enum t_sys_state {IDLE, RESP, TRAP}; t_sysop SHALL be reused from multicore_pkg.
REQ-036 A sub-module sys_counter64 (64-bit counter with synchronous reset and enable) SHALL be instantiated three times.

Verification
REQ-037 Release rst, wait 100 cycles, then issue RDCYCLE -> resp_valid one cycle later with resp_data = cycle value at the accept edge (100, +/-0 per REQ-025); resp_rd echoed.
REQ-038 TIME_DIV=10, run 95 cycles after reset, then RDTIME -> resp_data=9; RDTIME issued 10 cycles later -> resp_data=10.
REQ-039 Preload cycle to 0x0000_0000_FFFF_FFFF via force, issue RDCYCLE then RDCYCLEH back-to-back -> 0xFFFF_FFFF then 0x0000_0001; also verify wrap from all-ones to 0.
REQ-040 Pulse retire 7 times, with the 7th coincident with an RDINSTRET accept -> resp_data=6; the next RDINSTRET -> 7.
REQ-041 SCALL accepted (SYSUNIT_TRAP_EN defined) -> trap_valid=1, trap_cause=0, req_ready=0 until trap_ack at cycle +5 -> IDLE next cycle, no resp_valid; repeat with rst asserted at cycle +2 -> trap_valid=0 next cycle.
REQ-042 SBREAK without SYSUNIT_TRAP_EN -> resp_valid with resp_data=0, trap_valid never asserted.
